sbtm_arb_ctrl: RTL and testbench

SBTM_ARB_CTRL -- requirements
Module: sbtm_arb_ctrl

---
 rtl/sbtm_arb_ctrl_if.sv | 34 +++
 rtl/sbtm_arb_ctrl.sv | 133 +++++++++++++
 tb/tb_sbtm_arb_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbtm_arb_ctrl_if.sv
// sbtm_arb_ctrl_if: bundles the requester, ROM and result signals of sbtm_arb_ctrl.
//   in0_*/in1_*  : two valid/ready operand requesters (8-bit operand)
//   rom_a0_*     : 32x8 a0 table, combinational read
//   rom_a1_*     : 16x3 a1 table, combinational read
//   out_*        : valid/ready result channel (8-bit result, 1-bit requester id)
//   busy         : any pipeline stage occupied
// Modport slave is the arbiter/pipeline side; master is the environment side.
interface sbtm_arb_ctrl_if;
    logic       in0_valid;
    logic [7:0] in0_x;
    logic       in0_ready;
    logic       in1_valid;
    logic [7:0] in1_x;
    logic       in1_ready;
    logic [4:0] rom_a0_addr;
    logic [7:0] rom_a0_data;
    logic [3:0] rom_a1_addr;
    logic [2:0] rom_a1_data;
    logic       out_valid;
    logic [7:0] out_y;
    logic       out_id;
    logic       out_ready;
    logic       busy;

    modport slave (
        input  in0_valid, in0_x, in1_valid, in1_x, rom_a0_data, rom_a1_data, out_ready,
        output in0_ready, in1_ready, rom_a0_addr, rom_a1_addr, out_valid, out_y, out_id, busy
    );

    modport master (
        output in0_valid, in0_x, in1_valid, in1_x, rom_a0_data, rom_a1_data, out_ready,
        input  in0_ready, in1_ready, rom_a0_addr, rom_a1_addr, out_valid, out_y, out_id, busy
    );
endinterface

// File: rtl/sbtm_arb_ctrl.sv
// sbtm_arb_ctrl: two-requester arbiter feeding a 3-stage SBTM (symmetric bipartite table)
// evaluation pipeline.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sbtm_arb_ctrl_if.slave (requesters, ROM ports, result channel, busy)
// Stage 1 holds the granted operand and drives the ROM addresses, stage 2 holds the table
// outputs, stage 3 holds the clamped result. The whole pipe freezes while a result is
// presented and not taken.
module sbtm_arb_ctrl #(
    parameter bit FAIR = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    sbtm_arb_ctrl_if.slave  bus
);
    logic       s1_valid_q, s1_valid_d;
    logic [7:0] s1_x_q, s1_x_d;
    logic       s1_id_q, s1_id_d;
    logic       s2_valid_q, s2_valid_d;
    logic [7:0] s2_a0_q, s2_a0_d;
    logic [2:0] s2_a1_q, s2_a1_d;
    logic       s2_s_q, s2_s_d;
    logic       s2_id_q, s2_id_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_y_q, out_y_d;
    logic       out_id_q, out_id_d;
    logic       last_grant_q, last_grant_d;

    logic       en;
    logic       grant;
    logic       rdy0, rdy1, accept;
    logic [9:0] t;

    assign en = !(out_valid_q && !bus.out_ready);

    always_comb begin
        grant = 1'b0;
        if (bus.in0_valid && bus.in1_valid) begin
            grant = FAIR ? ~last_grant_q : 1'b0;
        end else if (bus.in1_valid) begin
            grant = 1'b1;
        end
        rdy0   = en && !grant && bus.in0_valid;
        rdy1   = en && grant && bus.in1_valid;
        accept = rdy0 || rdy1;
    end

    // 10-bit two's complement: bit 9 flags a negative difference, bit 8 an overflow past 255.
    always_comb begin
        if (s2_s_q) begin
            t = {2'b00, s2_a0_q} + {7'b0000000, s2_a1_q};
        end else begin
            t = {2'b00, s2_a0_q} - {7'b0000000, s2_a1_q};
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_x_d       = s1_x_q;
        s1_id_d      = s1_id_q;
        s2_valid_d   = s2_valid_q;
        s2_a0_d      = s2_a0_q;
        s2_a1_d      = s2_a1_q;
        s2_s_d       = s2_s_q;
        s2_id_d      = s2_id_q;
        out_valid_d  = out_valid_q;
        out_y_d      = out_y_q;
        out_id_d     = out_id_q;
        last_grant_d = last_grant_q;
        if (en) begin
            s1_valid_d  = accept;
            s1_x_d      = grant ? bus.in1_x : bus.in0_x;
            s1_id_d     = grant;
            s2_valid_d  = s1_valid_q;
            s2_a0_d     = bus.rom_a0_data;
            s2_a1_d     = bus.rom_a1_data;
            s2_s_d      = s1_x_q[2];
            s2_id_d     = s1_id_q;
            out_valid_d = s2_valid_q;
            out_id_d    = s2_id_q;
            if (t[9]) begin
                out_y_d = 8'd0;
            end else if (t[8]) begin
                out_y_d = 8'd255;
            end else begin
                out_y_d = t[7:0];
            end
            if (accept) begin
                last_grant_d = grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_x_q       <= 8'd0;
            s1_id_q      <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_a0_q      <= 8'd0;
            s2_a1_q      <= 3'd0;
            s2_s_q       <= 1'b0;
            s2_id_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_y_q      <= 8'd0;
            out_id_q     <= 1'b0;
            last_grant_q <= 1'b1;  // requester 0 wins the first tie
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_a0_q      <= s2_a0_d;
            s2_a1_q      <= s2_a1_d;
            s2_s_q       <= s2_s_d;
            s2_id_q      <= s2_id_d;
            out_valid_q  <= out_valid_d;
            out_y_q      <= out_y_d;
            out_id_q     <= out_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // a1 table stores one half of the symmetric term; the other half is read mirrored.
    assign bus.rom_a0_addr = s1_x_q[7:3];
    assign bus.rom_a1_addr = {s1_x_q[7:6], (s1_x_q[2] ? s1_x_q[1:0] : ~s1_x_q[1:0])};
    assign bus.in0_ready   = rdy0;
    assign bus.in1_ready   = rdy1;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_y       = out_y_q;
    assign bus.out_id      = out_id_q;
    assign bus.busy        = s1_valid_q | s2_valid_q | out_valid_q;
endmodule

// File: tb/tb_sbtm_arb_ctrl.sv
// Testbench for sbtm_arb_ctrl: directed vector table, fairness/stall/reset sequences and
// randomized traffic against an in-flight-list reference model.
module tb_sbtm_arb_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sbtm_arb_ctrl_if bus();

    sbtm_arb_ctrl #(.FAIR(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM model: a0[k] = 8*k, a1[k] = k[2:0]
    assign bus.rom_a0_data = {bus.rom_a0_addr, 3'b000};
    assign bus.rom_a1_data = bus.rom_a1_addr[2:0];

    int checks   = 0;
    int failures = 0;

    // Reference model: each accepted operand with the number of enabled edges it has seen.
    int q_x[$];
    int q_id[$];
    int q_age[$];
    bit m_last;
    int n_acc;
    int obs_id[$];
    int obs_y[$];

    typedef struct {
        logic [7:0] x;
        int         a0_addr;
        int         a1_addr;
        int         y;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int a0_addr_of(input int x);
        return x / 8;
    endfunction

    function automatic int a1_addr_of(input int x);
        int low;
        int f;
        low = x % 4;
        f = ((x / 4) % 2 == 1) ? low : 3 - low;
        return (x / 64) * 4 + f;
    endfunction

    function automatic int sbtm_of(input int x);
        int a0;
        int a1;
        int t;
        a0 = 8 * a0_addr_of(x);
        a1 = a1_addr_of(x) % 8;
        t = ((x / 4) % 2 == 1) ? a0 + a1 : a0 - a1;
        if (t < 0) return 0;
        if (t > 255) return 255;
        return t;
    endfunction

    // One clock: sample at the falling edge, check against the model, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic cycle();
        bit exp_ov;
        bit en;
        bit g;
        bit r0;
        bit r1;
        @(negedge clk);
        exp_ov = (q_age.size() > 0) && (q_age[0] == 3);
        en = !(exp_ov && !bus.out_ready);
        if (bus.in0_valid && bus.in1_valid) g = ~m_last;
        else g = bus.in1_valid;
        r0 = en && !g && bus.in0_valid;
        r1 = en && g && bus.in1_valid;
        chk("in0_ready", bus.in0_ready, r0);
        chk("in1_ready", bus.in1_ready, r1);
        chk("out_valid", bus.out_valid, exp_ov);
        chk("busy", bus.busy, q_age.size() != 0);
        if (exp_ov) begin
            chk("out_y", bus.out_y, sbtm_of(q_x[0]));
            chk("out_id", bus.out_id, q_id[0]);
        end
        for (int i = 0; i < q_age.size(); i++) begin
            if (q_age[i] == 1) begin
                chk("rom_a0_addr", bus.rom_a0_addr, a0_addr_of(q_x[i]));
                chk("rom_a1_addr", bus.rom_a1_addr, a1_addr_of(q_x[i]));
            end
        end
        if (en) begin
            if (exp_ov) begin
                obs_id.push_back(int'(bus.out_id));
                obs_y.push_back(int'(bus.out_y));
                void'(q_x.pop_front());
                void'(q_id.pop_front());
                void'(q_age.pop_front());
            end
            for (int i = 0; i < q_age.size(); i++) q_age[i]++;
            if (r0 || r1) begin
                q_x.push_back(g ? int'(bus.in1_x) : int'(bus.in0_x));
                q_id.push_back(int'(g));
                q_age.push_back(1);
                m_last = g;
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; reset is released before the next edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_y", bus.out_y, 8'd0);
        chk("rst_out_id", bus.out_id, 1'b0);
        q_x.delete();
        q_id.delete();
        q_age.delete();
        m_last = 1'b1;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q_age.size() > 0; i++) cycle();
        chk("drain_empty", q_age.size(), 0);
    endtask

    task automatic single_op(input vec_t v);
        bus.in0_valid = 1'b1;
        bus.in0_x     = v.x;
        cycle();
        bus.in0_valid = 1'b0;
        chk("vec_a0_addr", bus.rom_a0_addr, v.a0_addr);
        chk("vec_a1_addr", bus.rom_a1_addr, v.a1_addr);
        cycle();
        cycle();
        chk("vec_out_valid", bus.out_valid, 1'b1);
        chk("vec_out_y", bus.out_y, v.y);
        chk("vec_out_id", bus.out_id, 1'b0);
        cycle();
    endtask

    initial begin
        vec_t vecs[7];
        logic [7:0] y0;
        logic       id0;
        int         base;

        vecs[0] = '{x: 8'h2C, a0_addr: 5,  a1_addr: 0,  y: 40};
        vecs[1] = '{x: 8'h28, a0_addr: 5,  a1_addr: 3,  y: 37};
        vecs[2] = '{x: 8'h00, a0_addr: 0,  a1_addr: 3,  y: 0};
        vecs[3] = '{x: 8'hFF, a0_addr: 31, a1_addr: 15, y: 255};
        vecs[4] = '{x: 8'h83, a0_addr: 16, a1_addr: 8,  y: 128};
        vecs[5] = '{x: 8'h47, a0_addr: 8,  a1_addr: 7,  y: 71};
        vecs[6] = '{x: 8'hF8, a0_addr: 31, a1_addr: 15, y: 241};

        rst_n         = 1'b1;
        bus.in0_valid = 1'b0;
        bus.in0_x     = 8'h00;
        bus.in1_valid = 1'b0;
        bus.in1_x     = 8'h00;
        bus.out_ready = 1'b1;
        n_acc         = 0;
        m_last        = 1'b1;
        @(posedge clk);
        #1;
        pulse_reset();

        // Directed vectors, issued right after reset release
        for (int i = 0; i < 7; i++) single_op(vecs[i]);
        drain();

        // Fair arbitration from reset: 0,1,0,1
        pulse_reset();
        obs_id.delete();
        bus.in0_valid = 1'b1;
        bus.in0_x     = 8'h2C;
        bus.in1_valid = 1'b1;
        bus.in1_x     = 8'h28;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fair_ready0", bus.in0_ready, (k % 2) == 0);
            chk("fair_ready1", bus.in1_ready, (k % 2) == 1);
            cycle();
        end
        drain();
        chk("fair_count", obs_id.size(), 4);
        if (obs_id.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("fair_out_id", obs_id[k], k % 2);
        end

        // Stall with a full pipe
        obs_y.delete();
        base = n_acc;
        bus.in0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in0_x = 8'(k * 37 + 5);
            cycle();
        end
        bus.out_ready = 1'b0;
        bus.in0_x     = 8'hA5;
        #1;
        y0  = bus.out_y;
        id0 = bus.out_id;
        chk("stall_full", bus.out_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_y", bus.out_y, y0);
            chk("stall_id", bus.out_id, id0);
            chk("stall_rdy0", bus.in0_ready, 1'b0);
            chk("stall_rdy1", bus.in1_ready, 1'b0);
        end
        drain();
        chk("stall_no_loss", obs_y.size(), n_acc - base);

        // Reset with three entries in flight
        bus.in0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in0_x = 8'(k * 50 + 9);
            cycle();
        end
        bus.in0_valid = 1'b0;
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        pulse_reset();
        obs_y.delete();
        bus.in0_valid = 1'b1;
        bus.in0_x     = 8'h2C;
        cycle();
        drain();
        chk("post_rst_count", obs_y.size(), 1);
        if (obs_y.size() > 0) chk("post_rst_y", obs_y[0], 40);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            bus.in0_valid = 1'($urandom_range(0, 1));
            bus.in1_valid = 1'($urandom_range(0, 1));
            bus.in0_x     = 8'($urandom);
            bus.in1_x     = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
